fetch_stage: RTL and testbench
==============================

FETCH_STAGE -- requirements
Module: fetch_stage

Interface
REQ-001 SHALL have parameter RESET_PC, default 32'h0000_0000: byte address loaded into the PC on reset.
REQ-002 SHALL have parameter IMEM_DEPTH, default 128: instruction memory depth in 32-bit words.
REQ-003 SHALL have port clk, input, 1: the single clock; all state updates on its rising edge.
REQ-004 SHALL have port reset, input, 1: synchronous, active-high reset.
REQ-005 SHALL have port Address, output, 32: word index driven to instruction memory, equal to {2'b00, PC[31:2]}.
REQ-006 SHALL have port Instruction, input, 32: combinational instruction memory read data for Address.
REQ-007 SHALL have port Stall, input, 1: hazard hold request from decode.
REQ-008 SHALL have port Flush, input, 1: taken-branch/jump redirect request.
REQ-009 SHALL have port BranchTarget, input, 32: byte address of the redirect target.
REQ-010 SHALL have port IFID_Instr, output, 32: registered instruction for decode.
REQ-011 SHALL have port IFID_PCPlus4, output, 32: registered PC+4 of IFID_Instr.
REQ-012 SHALL have port IFID_Valid, output, 1: IFID_Instr holds a real instruction; 0 means bubble.
REQ-013 SHALL have port PC, output, 32: current fetch byte address.
REQ-014 SHALL have port FetchFault, output, 1: sticky out-of-range fetch flag (see Configuration).

Function
REQ-015 SHALL drive Address combinationally from PC with zero added latency; Instruction is sampled in the same cycle.
REQ-016 SHALL, on an edge with Stall=0 and Flush=0, load IFID_Instr<=Instruction, IFID_PCPlus4<=PC+4, IFID_Valid<=1, and PC<=PC+4.
REQ-017 SHALL, on an edge with Stall=1 and Flush=0, hold PC, IFID_Instr, IFID_PCPlus4 and IFID_Valid unchanged.
REQ-018 SHALL, on an edge with Flush=1, load PC<={BranchTarget[31:2],2'b00} and set IFID_Instr<=0, IFID_PCPlus4<=0, IFID_Valid<=0, regardless of Stall.
REQ-019 SHALL ignore BranchTarget[1:0]; misaligned targets are aligned down silently.
REQ-020 SHALL compute PC+4 modulo 2^32; PC=32'hFFFF_FFFC increments to 32'h0000_0000.
REQ-021 SHALL give reset priority over Flush, Flush over Stall, and Stall over normal advance.
REQ-022 SHALL present the first valid instruction (IMEM[RESET_PC>>2]) on IFID_Instr one cycle after reset deasserts, with no stall.
REQ-023 SHALL have a one-cycle branch penalty: exactly one IFID_Valid=0 bubble follows each Flush.

Reset
REQ-024 SHALL, on a rising edge with reset=1, set PC<=RESET_PC, IFID_Instr<=0, IFID_PCPlus4<=0, IFID_Valid<=0, FetchFault<=0, regardless of Stall and Flush.
REQ-025 SHALL treat reset asserted mid-stall or mid-flush identically to reset from idle; no pending request survives.

Configuration
REQ-026 SHALL compile in out-of-range fetch detection when macro FETCH_BOUNDS_CHECK_EN is defined.
REQ-027 SHALL, with FETCH_BOUNDS_CHECK_EN defined, treat PC[31:2] >= IMEM_DEPTH on a non-stalled edge as a fault: FetchFault<=1, IFID_Instr<=0, IFID_Valid<=0, PC held.
REQ-028 SHALL, with FETCH_BOUNDS_CHECK_EN defined, keep FetchFault sticky and PC frozen, ignoring Flush and Stall, until reset.
REQ-029 SHALL, without FETCH_BOUNDS_CHECK_EN, tie FetchFault to 0 and fetch any PC unchecked.

Verification
REQ-030 SHALL cover: reset with RESET_PC=0, IMEM[0]=32'h014A5020, IMEM[1]=32'h00221822 -> cycle 1 IFID_Instr=32'h014A5020, IFID_PCPlus4=4; cycle 2 IFID_Instr=32'h00221822, PC=8.
REQ-031 SHALL cover: Stall=1 for 3 cycles at PC=8 -> PC, IFID_Instr and IFID_Valid constant for 3 cycles; advance resumes on the cycle Stall drops.
REQ-032 SHALL cover: Flush=1, BranchTarget=32'h0000_0013 -> next edge PC=32'h10, IFID_Valid=0, IFID_Instr=0; following edge IFID_Instr=IMEM[4].
REQ-033 SHALL cover: Flush=1 and Stall=1 on the same edge -> flush behaviour of REQ-018; reset=1 with Flush=1 -> PC=RESET_PC.
REQ-034 SHALL cover, with FETCH_BOUNDS_CHECK_EN: Flush to 32'h200 (word 128) -> next edge FetchFault=1, IFID_Valid=0, PC stays 32'h200 through a later Flush; reset clears it.
REQ-035 SHALL cover, without FETCH_BOUNDS_CHECK_EN: same stimulus as REQ-034 -> FetchFault=0 and PC advances to 32'h204.

Source files
------------

// File: rtl/fetch_stage.sv
// Instruction fetch stage: PC register, IF/ID pipeline register, stall/flush handling.
// Optional out-of-range fetch detection is compiled in with FETCH_BOUNDS_CHECK_EN.
module fetch_stage #(
  parameter logic [31:0] RESET_PC   = 32'h0000_0000,
  parameter int          IMEM_DEPTH = 128
) (
  input  logic        clk,
  input  logic        reset,
  output logic [31:0] Address,
  input  logic [31:0] Instruction,
  input  logic        Stall,
  input  logic        Flush,
  input  logic [31:0] BranchTarget,
  output logic [31:0] IFID_Instr,
  output logic [31:0] IFID_PCPlus4,
  output logic        IFID_Valid,
  output logic [31:0] PC,
  output logic        FetchFault
);

`ifdef FETCH_BOUNDS_CHECK_EN
  localparam logic CHECK_EN = 1'b1;
`else
  localparam logic CHECK_EN = 1'b0;
`endif

  localparam logic [31:0] DEPTH_W = 32'(IMEM_DEPTH);

  logic [31:0] pc_q, pc_d;
  logic [31:0] instr_q, instr_d;
  logic [31:0] pc_plus4_q, pc_plus4_d;
  logic        valid_q, valid_d;
  logic        fault_q, fault_d;

  logic [31:0] pc_plus4;
  logic [31:0] word_index;
  logic        out_of_range;

  // Word index doubles as the memory address; the add wraps naturally at 2^32.
  assign word_index   = {2'b00, pc_q[31:2]};
  assign pc_plus4     = pc_q + 32'd4;
  assign out_of_range = CHECK_EN && (word_index >= DEPTH_W);

  always_comb begin
    pc_d       = pc_q;
    instr_d    = instr_q;
    pc_plus4_d = pc_plus4_q;
    valid_d    = valid_q;
    fault_d    = fault_q;

    if (fault_q) begin
      // Faulted: everything frozen until reset, redirects included.
      pc_d = pc_q;
    end else if (Flush) begin
      pc_d       = BranchTarget & 32'hFFFF_FFFC;
      instr_d    = 32'h0;
      pc_plus4_d = 32'h0;
      valid_d    = 1'b0;
    end else if (Stall) begin
      pc_d = pc_q;
    end else if (out_of_range) begin
      fault_d = 1'b1;
      instr_d = 32'h0;
      valid_d = 1'b0;
    end else begin
      pc_d       = pc_plus4;
      instr_d    = Instruction;
      pc_plus4_d = pc_plus4;
      valid_d    = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      pc_q       <= RESET_PC;
      instr_q    <= 32'h0;
      pc_plus4_q <= 32'h0;
      valid_q    <= 1'b0;
      fault_q    <= 1'b0;
    end else begin
      pc_q       <= pc_d;
      instr_q    <= instr_d;
      pc_plus4_q <= pc_plus4_d;
      valid_q    <= valid_d;
      fault_q    <= fault_d;
    end
  end

  assign Address      = word_index;
  assign PC           = pc_q;
  assign IFID_Instr   = instr_q;
  assign IFID_PCPlus4 = pc_plus4_q;
  assign IFID_Valid   = valid_q;
  assign FetchFault   = fault_q;

endmodule

// File: tb/tb_fetch_stage.sv
// Table-driven bench for fetch_stage: one edge per vector, plus hand sequences
// for PC wrap-around and out-of-range fetch (expectations follow FETCH_BOUNDS_CHECK_EN).
module tb_fetch_stage;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] Address;
  logic [31:0] Instruction;
  logic        Stall;
  logic        Flush;
  logic [31:0] BranchTarget;
  logic [31:0] IFID_Instr;
  logic [31:0] IFID_PCPlus4;
  logic        IFID_Valid;
  logic [31:0] PC;
  logic        FetchFault;

  int errors = 0;
  int checks = 0;

  logic [31:0] imem [0:127];

  fetch_stage #(.RESET_PC(32'h0000_0000), .IMEM_DEPTH(128)) dut (
    .clk(clk), .reset(reset), .Address(Address), .Instruction(Instruction),
    .Stall(Stall), .Flush(Flush), .BranchTarget(BranchTarget),
    .IFID_Instr(IFID_Instr), .IFID_PCPlus4(IFID_PCPlus4), .IFID_Valid(IFID_Valid),
    .PC(PC), .FetchFault(FetchFault)
  );

  always #5 clk = ~clk;

  // Out-of-range words return a recognisable pattern tagged with the low address bits.
  assign Instruction = (Address < 32'd128) ? imem[Address[6:0]]
                                           : (32'hBAD0_0000 | {16'h0, Address[15:0]});

  typedef struct {
    logic        rst;
    logic        stall;
    logic        flush;
    logic [31:0] target;
    logic [31:0] pc;
    logic [31:0] instr;
    logic [31:0] p4;
    logic        valid;
  } vec_t;

  vec_t vecs [15];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %08h expected %08h", name, act, exp);
    end
  endtask

  task automatic step(input logic r, input logic s, input logic f, input logic [31:0] t);
    @(negedge clk);
    reset = r; Stall = s; Flush = f; BranchTarget = t;
    @(posedge clk);
    #1;
  endtask

  task automatic check_state(input string tag, input logic [31:0] pc, input logic [31:0] instr,
                             input logic [31:0] p4, input logic valid, input logic fault);
    check({tag, ".pc"},    PC, pc);
    check({tag, ".addr"},  Address, {2'b00, pc[31:2]});
    check({tag, ".instr"}, IFID_Instr, instr);
    check({tag, ".p4"},    IFID_PCPlus4, p4);
    check({tag, ".valid"}, {31'h0, IFID_Valid}, {31'h0, valid});
    check({tag, ".fault"}, {31'h0, FetchFault}, {31'h0, fault});
    $display("txn %s: pc=%08h instr=%08h p4=%08h valid=%0b fault=%0b",
             tag, PC, IFID_Instr, IFID_PCPlus4, IFID_Valid, FetchFault);
  endtask

  initial begin
    for (int i = 0; i < 128; i++) imem[i] = 32'h1000_0000 | i;
    imem[0] = 32'h014A5020;
    imem[1] = 32'h00221822;

    //          rst   stall flush target         pc            instr          p4            valid
    vecs[0]  = '{1'b1, 1'b0, 1'b0, 32'h0,        32'h0,        32'h0,         32'h0,        1'b0};
    vecs[1]  = '{1'b1, 1'b1, 1'b1, 32'h40,       32'h0,        32'h0,         32'h0,        1'b0};
    vecs[2]  = '{1'b0, 1'b0, 1'b0, 32'h0,        32'h4,        32'h014A5020,  32'h4,        1'b1};
    vecs[3]  = '{1'b0, 1'b0, 1'b0, 32'h0,        32'h8,        32'h00221822,  32'h8,        1'b1};
    vecs[4]  = '{1'b0, 1'b1, 1'b0, 32'h0,        32'h8,        32'h00221822,  32'h8,        1'b1};
    vecs[5]  = '{1'b0, 1'b1, 1'b0, 32'h0,        32'h8,        32'h00221822,  32'h8,        1'b1};
    vecs[6]  = '{1'b0, 1'b1, 1'b0, 32'h0,        32'h8,        32'h00221822,  32'h8,        1'b1};
    vecs[7]  = '{1'b0, 1'b0, 1'b0, 32'h0,        32'hC,        32'h1000_0002, 32'hC,        1'b1};
    vecs[8]  = '{1'b0, 1'b0, 1'b1, 32'h13,       32'h10,       32'h0,         32'h0,        1'b0};
    vecs[9]  = '{1'b0, 1'b0, 1'b0, 32'h0,        32'h14,       32'h1000_0004, 32'h14,       1'b1};
    vecs[10] = '{1'b0, 1'b1, 1'b1, 32'h2A,       32'h28,       32'h0,         32'h0,        1'b0};
    vecs[11] = '{1'b0, 1'b1, 1'b0, 32'h0,        32'h28,       32'h0,         32'h0,        1'b0};
    vecs[12] = '{1'b0, 1'b0, 1'b0, 32'h0,        32'h2C,       32'h1000_000A, 32'h2C,       1'b1};
    vecs[13] = '{1'b1, 1'b0, 1'b1, 32'h80,       32'h0,        32'h0,         32'h0,        1'b0};
    vecs[14] = '{1'b0, 1'b0, 1'b0, 32'h0,        32'h4,        32'h014A5020,  32'h4,        1'b1};

    reset = 1'b1; Stall = 1'b0; Flush = 1'b0; BranchTarget = 32'h0;

    for (int v = 0; v < 15; v++) begin
      step(vecs[v].rst, vecs[v].stall, vecs[v].flush, vecs[v].target);
      check_state($sformatf("vec%0d", v), vecs[v].pc, vecs[v].instr, vecs[v].p4, vecs[v].valid, 1'b0);
    end

    // PC wrap: redirect to the last word, then advance.
    step(1'b0, 1'b0, 1'b1, 32'hFFFF_FFFE);
    check_state("wrap_flush", 32'hFFFF_FFFC, 32'h0, 32'h0, 1'b0, 1'b0);
    step(1'b0, 1'b0, 1'b0, 32'h0);
`ifdef FETCH_BOUNDS_CHECK_EN
    check_state("wrap_adv", 32'hFFFF_FFFC, 32'h0, 32'h0, 1'b0, 1'b1);
`else
    check_state("wrap_adv", 32'h0, 32'hBAD0_FFFF, 32'h0, 1'b1, 1'b0);
`endif

    // Out-of-range fetch at word 128.
    step(1'b1, 1'b0, 1'b0, 32'h0);
    check_state("oor_reset", 32'h0, 32'h0, 32'h0, 1'b0, 1'b0);
    step(1'b0, 1'b0, 1'b1, 32'h200);
    check_state("oor_flush", 32'h200, 32'h0, 32'h0, 1'b0, 1'b0);
    step(1'b0, 1'b0, 1'b0, 32'h0);
`ifdef FETCH_BOUNDS_CHECK_EN
    check_state("oor_fetch", 32'h200, 32'h0, 32'h0, 1'b0, 1'b1);
    step(1'b0, 1'b0, 1'b1, 32'h40);
    check_state("oor_frozen", 32'h200, 32'h0, 32'h0, 1'b0, 1'b1);
`else
    check_state("oor_fetch", 32'h204, 32'hBAD0_0080, 32'h204, 1'b1, 1'b0);
    step(1'b0, 1'b0, 1'b1, 32'h40);
    check_state("oor_redirect", 32'h40, 32'h0, 32'h0, 1'b0, 1'b0);
`endif
    step(1'b1, 1'b1, 1'b1, 32'h80);
    check_state("oor_clear", 32'h0, 32'h0, 32'h0, 1'b0, 1'b0);
    step(1'b0, 1'b0, 1'b0, 32'h0);
    check_state("oor_resume", 32'h4, 32'h014A5020, 32'h4, 1'b1, 1'b0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
